// File: rtl/mem_stage_if.sv
// Data-memory port of the Beta memory stage: a single outstanding req/ack
// transaction, with the stage as master and the memory as slave.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage.sv
// Beta memory-access stage: registers the execute outputs, runs LD/LDR/ST on
// the data-memory port (stalling while outstanding) and selects the writeback value.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic [1:0]  ir_src_mem,
  input  logic        op_ld_or_ldr,
  input  logic        op_st,
  input  logic        rf_w_mux_jump,
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] y,
  input  logic [31:0] d,
  mem_stage_if.master dmem,
  output logic        stall_mem,
  output logic        mem_fault,
  output logic [31:0] pc_next,
  output logic [31:0] ir_next,
  output logic [31:0] wb_data_next
);

  localparam logic [31:0] INST_NOP        = 32'hC3FF_0000;
  localparam logic [31:0] INST_BNE_EXCEPT = 32'h7BDF_0000;
  localparam logic [1:0]  IR_SRC_DATA     = 2'd0;
  localparam logic [1:0]  IR_SRC_NOP      = 2'd1;
  localparam logic [1:0]  IR_SRC_EXCEPT   = 2'd2;
  localparam logic [7:0]  CNT_LAST        = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_pc_mem, r_ir_mem, r_y_mem, r_d_mem, r_rdata_q;
  logic        r_ld_mem, r_st_mem, r_jmp_mem;
  logic        w_mem_op, w_advance, w_ack;

  assign w_mem_op   = r_ld_mem | r_st_mem;
  assign w_ack      = dmem.req & dmem.ack;
  assign stall_mem  = dmem.req & ~dmem.ack & ~mem_fault;
  assign w_advance  = ~(stall_in | stall_mem);
  assign dmem.addr  = r_y_mem;
  assign dmem.wdata = r_d_mem;
  assign dmem.we    = r_st_mem & dmem.req;
  assign pc_next    = r_pc_mem;

  // ---- stage registers (execute -> memory boundary)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_mem  <= '0;
      r_ir_mem  <= INST_NOP;
      r_y_mem   <= '0;
      r_d_mem   <= '0;
      r_ld_mem  <= 1'b0;
      r_st_mem  <= 1'b0;
      r_jmp_mem <= 1'b0;
    end else if (w_advance) begin
      r_pc_mem  <= pc;
      r_ir_mem  <= ir;
      r_y_mem   <= y;
      r_d_mem   <= d;
      r_ld_mem  <= op_ld_or_ldr;
      r_st_mem  <= op_st;
      r_jmp_mem <= rf_w_mux_jump;
    end
  end

  // Keeps the loaded word for the cycles the FSM parks in HOLD.
  always_ff @(posedge clk) begin
    if (w_ack) r_rdata_q <= dmem.rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op && dmem.ack) begin
          w_state_nxt = stall_in ? S_HOLD : S_IDLE;
        end else if (w_mem_op) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 8'd1;
        end
      end
      S_WAIT: begin
        if (dmem.ack)               w_state_nxt = stall_in ? S_HOLD : S_IDLE;
        else if (r_cnt == CNT_LAST) w_state_nxt = S_IDLE;
        else                        w_cnt_nxt   = r_cnt + 8'd1;
      end
      S_HOLD: begin
        if (!stall_in) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // An ack on the last counted cycle takes priority over the timeout.
  always_comb begin
    dmem.req  = 1'b0;
    mem_fault = 1'b0;
    case (r_state)
      S_IDLE: dmem.req = w_mem_op;
      S_WAIT: begin
        dmem.req  = 1'b1;
        mem_fault = ~dmem.ack & (r_cnt == CNT_LAST);
      end
      default: dmem.req = 1'b0;
    endcase
  end

  always_comb begin
    if (r_jmp_mem)     wb_data_next = r_pc_mem;
    else if (r_ld_mem) wb_data_next = (r_state == S_HOLD) ? r_rdata_q : dmem.rdata;
    else               wb_data_next = r_y_mem;
  end

  always_comb begin
    if (mem_fault || ir_src_mem == IR_SRC_EXCEPT)    ir_next = INST_BNE_EXCEPT;
    else if (stall_mem || ir_src_mem == IR_SRC_NOP) ir_next = INST_NOP;
    else if (ir_src_mem == IR_SRC_DATA)             ir_next = r_ir_mem;
    else                                            ir_next = 'x;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the Beta pipeline. It sits directly downstream of the execute stage and upstream of writeback.
- It registers the execute outputs (pc, ir, ALU result y, store data d and the control flags).
- For LD/LDR/ST it runs a req/ack transaction on the data-memory port, and stalls the pipeline while that transaction is outstanding.
- It produces the writeback value: the loaded word, the ALU result, or the link PC for jumps.

Parameters:
- TIMEOUT, 16, number of cycles without dmem_ack after which the access is abandoned and a fault is raised (valid range 2..255).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- stall_in  in  1  global stall from other stages; hold the stage registers
- ir_src_mem  in  2  IR source select for this stage (IR_SRC_EXCEPT / IR_SRC_NOP / IR_SRC_DATA)
- op_ld_or_ldr  in  1  next-cycle flag: load (LD or LDR)
- op_st  in  1  next-cycle flag: store
- rf_w_mux_jump  in  1  next-cycle flag: writeback selects the PC
- pc, ir, y, d  in  32 each  next-cycle PC, instruction, ALU result and store data from execute
- dmem_rdata  in  32  read data from memory, valid when dmem_ack=1
- dmem_ack  in  1  memory completes the current request
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  byte address, equal to y_mem
- dmem_wdata  out  32  store data, equal to d_mem
- stall_mem  out  1  this stage is waiting on memory
- mem_fault  out  1  one-cycle pulse when an access times out
- pc_next, ir_next, wb_data_next  out  32 each  values presented to writeback

Behaviour:
- **Stage registers** (pc_mem, ir_mem, y_mem, d_mem, ld_mem, st_mem, jmp_mem):
  - Load on posedge clk when !(stall_in || stall_mem); otherwise hold.
  - Reset values: ir_mem = INST_NOP; all other registers 0.
- **Derived signals**:
  - mem_op = ld_mem | st_mem.
  - dmem_addr = y_mem and dmem_wdata = d_mem, combinational.
  - dmem_we = st_mem & dmem_req.
- **FSM**: states IDLE, WAIT, HOLD; reset to IDLE. An 8-bit counter cnt resets to 0.
- **IDLE**:
  - dmem_req = mem_op.
  - If mem_op & dmem_ack: zero-wait completion. Go to HOLD if stall_in, else stay in IDLE.
  - If mem_op & !dmem_ack: go to WAIT with cnt = 1.
- **WAIT**:
  - dmem_req = 1; address, data and we stay stable.
  - If dmem_ack: go to HOLD if stall_in, else to IDLE.
  - Else if cnt == TIMEOUT-1: mem_fault = 1 for that cycle, drop the request, go to IDLE. The instruction completes as an exception (see ir_next).
  - Otherwise cnt += 1.
- **HOLD**:
  - dmem_req = 0, so an acknowledged access is never re-issued.
  - Go to IDLE when !stall_in.
- **stall_mem** = dmem_req & !dmem_ack & !mem_fault. Combinational; a zero-wait ack produces no stall.
- **Read data capture**: rdata_q captures dmem_rdata on any ack cycle.
- **wb_data_next**:
  - pc_mem if jmp_mem.
  - Otherwise, if ld_mem: dmem_rdata on the ack cycle, rdata_q in HOLD.
  - Otherwise y_mem.
- **ir_next**:
  - INST_BNE_EXCEPT if mem_fault or ir_src_mem == IR_SRC_EXCEPT.
  - Otherwise INST_NOP if stall_mem or ir_src_mem == IR_SRC_NOP.
  - Otherwise ir_mem.
  - An undefined select gives 'x.
- **pc_next** = pc_mem.
- **Reset outputs**: dmem_req=0, dmem_we=0, stall_mem=0, mem_fault=0, ir_next=INST_NOP, pc_next=0, wb_data_next=0.
- **Reset mid-access**: the request drops immediately (asynchronous) and the FSM goes to IDLE; no partial completion.
- **dmem_ack outside a request**: ignored.
- **Simultaneous ack and timeout-count cycle**: the ack wins and there is no fault.
- **Back-to-back memory ops with zero-wait ack**: one instruction per cycle, no bubbles.

Test Plan:
- **Zero-wait load**: LD with y=0x100, ack in the same cycle with rdata=0xDEADBEEF -> dmem_req=1, dmem_we=0, stall_mem=0; next cycle wb_data_next=0xDEADBEEF and ir_next=LD.
- **3-cycle store**: ST with y=0x40, d=0x12345678, ack on the 3rd request cycle -> stall_mem=1 for 2 cycles; addr/wdata/we=1 stable throughout; ir_next=INST_NOP during the stall; ST issued exactly once.
- **Ack while stall_in=1**: load ack with rdata=0xA5A5A5A5 -> FSM in HOLD, dmem_req=0 for the remaining stall cycles, wb_data_next=0xA5A5A5A5 on release; no second request.
- **Timeout with TIMEOUT=4 and no ack**: req high 4 cycles; mem_fault pulses on the 4th; ir_next=INST_BNE_EXCEPT that cycle; the stage then advances.
- **Jump / ALU pass-through**: with jmp_mem=1 and pc=0x204, wb_data_next=0x204 and no memory request; an ADD with y=7 gives wb_data_next=7.
- **rst_n asserted in WAIT**: dmem_req drops the same cycle; after release the FSM is in IDLE, ir_next=INST_NOP and no fault occurs.
